// File: rtl/regbank_write_sequencer.sv
// Write-side front end for the 16-entry register bank: takes up to two write
// requests per cycle into a small in-order queue and drains one per cycle.
module regbank_write_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     a_valid,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     a_h,
    input  logic                     b_valid,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_data,
    input  logic                     b_h,
    output logic                     req_ready,
    input  logic                     wr_stall,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     wr_h,
    output logic [(1<<ADDR_W)-1:0]   pending_mask,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_NEAR_FULL
    } occ_t;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic              r_h_mem    [DEPTH];

    logic [CNT_W-1:0]  w_free;
    occ_t              w_occ;
    logic              w_same_addr;
    logic              w_a_kept;
    logic              w_push0;
    logic              w_push1;
    logic              w_pop;
    logic [ADDR_W-1:0] w_e0_addr;
    logic [DATA_W-1:0] w_e0_data;
    logic              w_e0_h;
    logic [PTR_W-1:0]  w_wr_ptr_p1;
    logic [CNT_W-1:0]  w_n_enq;
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [PTR_W-1:0]  w_rd_ptr_next;
    logic [NREG-1:0]   w_entry_onehot [DEPTH];

    // Occupancy class, derived purely from the registered count.
    assign w_free = DEPTH_C - r_count;

    always_comb begin
        w_occ = OCC_PARTIAL;
        if (r_count == '0) begin
            w_occ = OCC_EMPTY;
        end else if (w_free < TWO_C) begin
            w_occ = OCC_NEAR_FULL;
        end
    end

    assign req_ready = (w_occ != OCC_NEAR_FULL) && Reset;
    assign busy      = (w_occ != OCC_EMPTY);

    // A same-address pair collapses into one entry carrying B's payload.
    assign w_same_addr = (a_addr == b_addr);
    assign w_a_kept    = a_valid && !(b_valid && w_same_addr);
    assign w_push0     = req_ready && (a_valid || b_valid);
    assign w_push1     = req_ready && w_a_kept && b_valid;

    assign w_e0_addr   = w_a_kept ? a_addr : b_addr;
    assign w_e0_data   = w_a_kept ? a_data : b_data;
    assign w_e0_h      = w_a_kept ? a_h    : b_h;
    assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);

    assign wr_en = busy && !wr_stall;
    assign w_pop = wr_en;

    assign w_n_enq       = CNT_W'(w_push0) + CNT_W'(w_push1);
    assign w_count_next  = r_count + w_n_enq - CNT_W'(w_pop);
    assign w_wr_ptr_next = r_wr_ptr + PTR_W'(w_push0) + PTR_W'(w_push1);
    assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count  <= w_count_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    // Storage needs no reset; validity is tracked by pointers and count.
    always_ff @(posedge CLK) begin
        if (w_push0) begin
            r_addr_mem[r_wr_ptr] <= w_e0_addr;
            r_data_mem[r_wr_ptr] <= w_e0_data;
            r_h_mem[r_wr_ptr]    <= w_e0_h;
        end
        if (w_push1) begin
            r_addr_mem[w_wr_ptr_p1] <= b_addr;
            r_data_mem[w_wr_ptr_p1] <= b_data;
            r_h_mem[w_wr_ptr_p1]    <= b_h;
        end
    end

    assign wr_addr = busy ? r_addr_mem[r_rd_ptr] : '0;
    assign wr_data = busy ? r_data_mem[r_rd_ptr] : '0;
    assign wr_h    = busy ? r_h_mem[r_rd_ptr]    : 1'b0;

    // A slot is live when its distance from the head is below the count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] w_offset;
            logic             w_live;
            assign w_offset = PTR_W'(gi) - r_rd_ptr;
            assign w_live   = ({1'b0, w_offset} < r_count);
            assign w_entry_onehot[gi] = w_live ? (NREG'(1) << r_addr_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_mask = pending_mask | w_entry_onehot[i];
        end
    end

endmodule

// File: tb/tb_regbank_write_sequencer.sv
// Self-checking bench for regbank_write_sequencer: table-driven single-cycle
// request cases plus stall-fill and mid-operation reset sequences.
module tb_regbank_write_sequencer;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        a_valid = 1'b0;
    logic [3:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        a_h = 1'b0;
    logic        b_valid = 1'b0;
    logic [3:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        b_h = 1'b0;
    logic        req_ready;
    logic        wr_stall = 1'b0;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_h;
    logic [15:0] pending_mask;
    logic        busy;

    regbank_write_sequencer #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
        .CLK(CLK), .Reset(Reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_h(a_h),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_h(b_h),
        .req_ready(req_ready), .wr_stall(wr_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_h(wr_h),
        .pending_mask(pending_mask), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        h;
    } wr_t;

    typedef struct {
        logic        av; logic [3:0] aa; logic [31:0] ad; logic ah;
        logic        bv; logic [3:0] ba; logic [31:0] bd; logic bh;
        int          n;  wr_t e0; wr_t e1;
        logic        en1; logic [15:0] m1; logic [15:0] m2;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard: every bank write is matched against the oldest expected entry.
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: actual addr %0d data 0x%08h h %0b, required no write",
                         wr_addr, wr_data, wr_h);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wr_addr, wr_data, wr_h} !== mon_e) begin
                    n_err++;
                    $display("FAIL write: actual addr %0d data 0x%08h h %0b, required addr %0d data 0x%08h h %0b",
                             wr_addr, wr_data, wr_h, mon_e.addr, mon_e.data, mon_e.h);
                end else begin
                    $display("ok   write: addr %0d data 0x%08h h %0b", wr_addr, wr_data, wr_h);
                end
            end
        end
    end

    task automatic drive_req(input logic av, input logic [3:0] aa, input logic [31:0] ad, input logic ah,
                             input logic bv, input logic [3:0] ba, input logic [31:0] bd, input logic bh,
                             output bit acc);
        a_valid = av; a_addr = aa; a_data = ad; a_h = ah;
        b_valid = bv; b_addr = ba; b_data = bd; b_h = bh;
        @(negedge CLK);
        acc = (req_ready === 1'b1);
        @(posedge CLK);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && k < 64) begin
            @(negedge CLK);
            k++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: actual busy %0b after 64 cycles, required 0", busy);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual simulation still running at 100000, required finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[6];
    wr_t  pa[4];
    wr_t  pb[4];

    initial begin
        bit acc;
        int idx;

        vecs[0] = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0,
                    1, '{4'd3, 32'hDEADBEEF, 1'b1}, '{4'd0, 32'h0, 1'b0}, 1'b1, 16'h0008, 16'h0000};
        vecs[1] = '{1'b1, 4'd1, 32'h11, 1'b0, 1'b1, 4'd2, 32'h22, 1'b0,
                    2, '{4'd1, 32'h11, 1'b0}, '{4'd2, 32'h22, 1'b0}, 1'b1, 16'h0006, 16'h0004};
        vecs[2] = '{1'b1, 4'd5, 32'hAAAA, 1'b0, 1'b1, 4'd5, 32'hBBBB, 1'b1,
                    1, '{4'd5, 32'hBBBB, 1'b1}, '{4'd0, 32'h0, 1'b0}, 1'b1, 16'h0020, 16'h0000};
        vecs[3] = '{1'b0, 4'd9, 32'h99, 1'b1, 1'b1, 4'd15, 32'h12345678, 1'b1,
                    1, '{4'd15, 32'h12345678, 1'b1}, '{4'd0, 32'h0, 1'b0}, 1'b1, 16'h8000, 16'h0000};
        vecs[4] = '{1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd15, 32'h0, 1'b0,
                    2, '{4'd0, 32'hFFFFFFFF, 1'b1}, '{4'd15, 32'h0, 1'b0}, 1'b1, 16'h8001, 16'h8000};
        vecs[5] = '{1'b0, 4'd7, 32'h77, 1'b0, 1'b0, 4'd8, 32'h88, 1'b0,
                    0, '{4'd0, 32'h0, 1'b0}, '{4'd0, 32'h0, 1'b0}, 1'b0, 16'h0000, 16'h0000};

        for (int i = 0; i < 4; i++) begin
            pa[i] = '{4'(6 + 2 * i), 32'h6000_0000 + 32'(i), 1'b1};
            pb[i] = '{4'(7 + 2 * i), 32'h7000_0000 + 32'(i), 1'b0};
        end

        // Reset state
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_h", wr_h, 0);
        chk("rst_pending", pending_mask, 0);
        chk("rst_busy", busy, 0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(negedge CLK);
        chk("rst_release_ready", req_ready, 1);

        // Table-driven single-cycle request patterns from an empty queue
        for (int v = 0; v < 6; v++) begin
            wait_idle();
            drive_req(vecs[v].av, vecs[v].aa, vecs[v].ad, vecs[v].ah,
                      vecs[v].bv, vecs[v].ba, vecs[v].bd, vecs[v].bh, acc);
            chk($sformatf("vec%0d_accept", v), 32'(acc), 1);
            if (acc) begin
                if (vecs[v].n >= 1) exp_q.push_back(vecs[v].e0);
                if (vecs[v].n >= 2) exp_q.push_back(vecs[v].e1);
            end
            @(negedge CLK);
            chk($sformatf("vec%0d_wr_en", v), wr_en, 32'(vecs[v].en1));
            chk($sformatf("vec%0d_mask1", v), pending_mask, 32'(vecs[v].m1));
            @(negedge CLK);
            chk($sformatf("vec%0d_mask2", v), pending_mask, 32'(vecs[v].m2));
        end

        // Stall held with dual requests each cycle: fills after two accepts
        wait_idle();
        wr_stall = 1'b1;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive_req(1'b1, pa[idx].addr, pa[idx].data, pa[idx].h,
                      1'b1, pb[idx].addr, pb[idx].data, pb[idx].h, acc);
            if (acc) begin
                exp_q.push_back(pa[idx]);
                exp_q.push_back(pb[idx]);
                idx++;
            end
        end
        chk("stall_accepts", idx, 2);
        @(negedge CLK);
        chk("stall_req_ready", req_ready, 0);
        chk("stall_busy", busy, 1);
        chk("stall_wr_en", wr_en, 0);
        chk("stall_pending", pending_mask, 32'h03C0);
        chk("stall_head_addr", wr_addr, 6);
        chk("stall_head_data", wr_data, 32'h6000_0000);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("stall_hold_addr", wr_addr, 6);
        chk("stall_hold_data", wr_data, 32'h6000_0000);
        chk("stall_hold_h", wr_h, 1);
        @(posedge CLK);
        #1;
        wr_stall = 1'b0;
        @(negedge CLK);
        chk("drain_ready_cnt4", req_ready, 0);
        @(negedge CLK);
        chk("drain_ready_cnt3", req_ready, 0);
        @(negedge CLK);
        chk("drain_ready_cnt2", req_ready, 1);
        wait_idle();

        // Mid-operation reset discards three queued writes
        wr_stall = 1'b1;
        drive_req(1'b1, 4'd1, 32'hA1, 1'b0, 1'b1, 4'd2, 32'hB2, 1'b1, acc);
        if (acc) begin
            exp_q.push_back('{4'd1, 32'hA1, 1'b0});
            exp_q.push_back('{4'd2, 32'hB2, 1'b1});
        end
        drive_req(1'b1, 4'd3, 32'hA3, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, acc);
        if (acc) exp_q.push_back('{4'd3, 32'hA3, 1'b1});
        @(negedge CLK);
        chk("prerst_busy", busy, 1);
        chk("prerst_pending", pending_mask, 32'h000E);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("inrst_req_ready", req_ready, 0);
        @(posedge CLK);
        exp_q.delete();
        #1;
        Reset = 1'b1;
        @(negedge CLK);
        chk("postrst_busy", busy, 0);
        chk("postrst_pending", pending_mask, 0);
        chk("postrst_wr_en", wr_en, 0);
        chk("postrst_wr_addr", wr_addr, 0);
        chk("postrst_req_ready", req_ready, 1);
        @(posedge CLK);
        #1;
        wr_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("postrst_idle%0d_wr_en", c), wr_en, 0);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
